uart_rx_module: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_module_if.sv | 28 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_rx_module.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding, default line constants and the
//               clocks-per-bit helper used by the receiver (and a future tx).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 115200;

    // Integer truncation is intentional: bit timing rounds toward fewer clocks.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_module_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_module_if
// Description : Serial line input and received-byte output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_module_if;

    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_done_sig;
    logic       frame_err;

    modport master (
        input  rx_pin,
        output rx_data,
        output rx_done_sig,
        output frame_err
    );

    modport slave (
        input  rx_data,
        input  rx_done_sig,
        input  frame_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Free-running bit-timing counter with synchronous clear and a
//               terminal-count flag against a runtime compare value.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int unsigned WIDTH = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_term,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_term);

endmodule
`default_nettype wire

// File: rtl/uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_module
// Description : 8N1 UART receiver, LSB first, mid-bit sampling of a
//               synchronised rx_pin; emits a done or frame-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_rx_module_if.master  bus
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] C_HALF_TC = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] C_FULL_TC = CNT_W'(BAUD_DIV - 1);

    // Synchroniser and edge history all reset high so the line reads idle.
    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_fall;

    uart_state_t r_state;
    uart_state_t w_state_next;

    logic             w_clear;
    logic             w_tc;
    logic [CNT_W-1:0] w_term;
    logic             w_shift;
    logic             w_done;
    logic             w_ferr;

    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_done;
    logic       r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= bus.rx_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_fall = r_prev & ~r_s2;
    assign w_term = (r_state == START) ? C_HALF_TC : C_FULL_TC;

    uart_baud_cnt #(
        .WIDTH (CNT_W)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter is held clear in IDLE so START always begins from zero.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (w_fall) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tc) begin
                    w_clear      = 1'b1;
                    w_state_next = r_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_clear = 1'b1;
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tc) begin
                    w_clear      = 1'b1;
                    w_state_next = IDLE;
                    w_done       = r_s2;
                    w_ferr       = ~r_s2;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= w_done;
            r_frame_err <= w_ferr;
            if (r_state != DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx          <= r_bit_idx + 3'd1;
                r_shift[r_bit_idx] <= r_s2;
            end
            if (w_done) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign bus.rx_data     = r_rx_data;
    assign bus.rx_done_sig = r_rx_done;
    assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire
